ghostbus_host: RTL and testbench



---
 rtl/ghostbus_host.sv | 195 +++++++++++++++++++
 tb/tb_ghostbus_host.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ghostbus_host.sv
// ghostbus_host: ghostbus initiator. Turns a valid/ready request stream into
// single-cycle gb_we/gb_re strobes and returns one response word per access.
// Read data is captured RD_DELAY cycles after the gb_re cycle and held until
// the consumer accepts it.
//
// Optional feature macro: GHOSTBUS_HOST_AUTOINC_EN
//   defined   -> read bursts of req_len+1 words at incrementing addresses
//   undefined -> every read is a single word, req_len ignored
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   req_valid/req_ready           request handshake (req_ready combinational)
//   req_we, req_addr, req_wdata   request type, start address, write data
//   req_len                       extra read words (burst = req_len+1)
//   rsp_valid/rsp_ready           response handshake
//   rsp_rdata, rsp_last           read data (0 for write acks), final word flag
//   busy                          high whenever the host is not idle
//   gb_addr, gb_dout              registered bus address / write data
//   gb_we, gb_re                  registered single-cycle bus strobes
//   gb_din                        bus read data
module ghostbus_host #(
  parameter int unsigned AW       = 24,
  parameter int unsigned DW       = 32,
  parameter int unsigned RD_DELAY = 2,
  parameter int unsigned CW       = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  input  logic [CW-1:0] req_len,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_last,
  output logic          busy,
  output logic [AW-1:0] gb_addr,
  output logic [DW-1:0] gb_dout,
  output logic          gb_we,
  output logic          gb_re,
  input  logic [DW-1:0] gb_din
);

  localparam int unsigned DCW = 4;  // covers RD_DELAY-1 up to 14

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_WAIT,
    S_RESP
  } state_t;

  state_t         state_q, state_d;
  logic [DCW-1:0] dly_q, dly_d;
  logic [AW-1:0]  gb_addr_q, gb_addr_d;
  logic [DW-1:0]  gb_dout_q, gb_dout_d;
  logic           gb_we_q, gb_we_d;
  logic           gb_re_q, gb_re_d;
  logic [DW-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic           rsp_last_q, rsp_last_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic           busy_q, busy_d;

`ifdef GHOSTBUS_HOST_AUTOINC_EN
  logic [CW-1:0]  rem_q, rem_d;
`else
  logic           len_unused;
  assign len_unused = ^req_len;
`endif

  // Accept requests only in IDLE; reset forces the handshake off immediately.
  assign req_ready = (state_q == S_IDLE) && !rst;

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    dly_d       = dly_q;
    gb_addr_d   = gb_addr_q;
    gb_dout_d   = gb_dout_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_last_d  = rsp_last_q;
`ifdef GHOSTBUS_HOST_AUTOINC_EN
    rem_d       = rem_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          gb_addr_d = req_addr;
          if (req_we) begin
            gb_dout_d = req_wdata;
            state_d   = S_WRITE;
`ifdef GHOSTBUS_HOST_AUTOINC_EN
            rem_d     = '0;
`endif
          end else begin
            state_d   = S_READ;
`ifdef GHOSTBUS_HOST_AUTOINC_EN
            rem_d     = req_len;
`endif
          end
        end
      end
      S_WRITE: begin
        rsp_rdata_d = '0;
        rsp_last_d  = 1'b1;
        state_d     = S_RESP;
      end
      S_READ: begin
        dly_d   = DCW'(RD_DELAY - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (dly_q == '0) begin
          rsp_rdata_d = gb_din;
`ifdef GHOSTBUS_HOST_AUTOINC_EN
          rsp_last_d  = (rem_q == '0);
`else
          rsp_last_d  = 1'b1;
`endif
          state_d     = S_RESP;
        end else begin
          dly_d = dly_q - DCW'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
`ifdef GHOSTBUS_HOST_AUTOINC_EN
          if (rem_q != '0) begin
            rem_d     = rem_q - CW'(1);
            gb_addr_d = gb_addr_q + AW'(1);
            state_d   = S_READ;
          end else begin
            state_d   = S_IDLE;
          end
`else
          state_d = S_IDLE;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Strobes and status are registered copies of the state being entered.
    gb_we_d     = (state_d == S_WRITE);
    gb_re_d     = (state_d == S_READ);
    rsp_valid_d = (state_d == S_RESP);
    busy_d      = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      dly_q       <= '0;
      gb_addr_q   <= '0;
      gb_dout_q   <= '0;
      gb_we_q     <= 1'b0;
      gb_re_q     <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_last_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef GHOSTBUS_HOST_AUTOINC_EN
      rem_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      dly_q       <= dly_d;
      gb_addr_q   <= gb_addr_d;
      gb_dout_q   <= gb_dout_d;
      gb_we_q     <= gb_we_d;
      gb_re_q     <= gb_re_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_last_q  <= rsp_last_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
`ifdef GHOSTBUS_HOST_AUTOINC_EN
      rem_q       <= rem_d;
`endif
    end
  end

  assign gb_addr   = gb_addr_q;
  assign gb_dout   = gb_dout_q;
  assign gb_we     = gb_we_q;
  assign gb_re     = gb_re_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_last  = rsp_last_q;
  assign rsp_valid = rsp_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_ghostbus_host.sv
// Testbench for ghostbus_host: table-driven single accesses, hand-written
// burst / backpressure / reset sequences, and a randomized mixed run, all
// checked against an address-indexed bus model and burst arithmetic.
module tb_ghostbus_host;

  localparam int AW = 24;
  localparam int DW = 32;
  localparam int RD_DELAY = 2;
  localparam int CW = 8;

  logic          clk, rst;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [CW-1:0] req_len;
  logic          rsp_valid, rsp_ready, rsp_last, busy;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] gb_addr;
  logic [DW-1:0] gb_dout, gb_din;
  logic          gb_we, gb_re;

  ghostbus_host #(.AW(AW), .DW(DW), .RD_DELAY(RD_DELAY), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_last(rsp_last), .busy(busy),
    .gb_addr(gb_addr), .gb_dout(gb_dout), .gb_we(gb_we), .gb_re(gb_re),
    .gb_din(gb_din)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  // Bus contents seen by the host: one special word, otherwise a hash of the address.
  function automatic logic [DW-1:0] rdata_of(logic [AW-1:0] a);
    if (a == 24'h000020) return 32'h12345678;
    return ({8'h00, a} * 32'h9E3779B1) + 32'd1;
  endfunction

  // Number of response words a request should produce.
  function automatic int words_of(logic we, logic [CW-1:0] len);
    if (we) return 1;
`ifdef GHOSTBUS_HOST_AUTOINC_EN
    return int'(len) + 1;
`else
    return 1;
`endif
  endfunction

  // Bus model: gb_din is valid only in the cycle RD_DELAY after the gb_re cycle.
  int            bus_k = 0;
  logic [AW-1:0] bus_addr;
  always @(negedge clk) begin
    if (rst) begin
      bus_k  = 0;
      gb_din = $urandom;
    end else begin
      if (bus_k > 0) begin
        bus_k--;
        gb_din = (bus_k == 0) ? rdata_of(bus_addr) : $urandom;
      end else begin
        gb_din = $urandom;
      end
      if (gb_re) begin
        bus_k    = RD_DELAY;
        bus_addr = gb_addr;
      end
    end
  end

  // Monitor: records handshakes, strobes and responses with cycle stamps.
  typedef struct { logic we; logic [AW-1:0] addr; logic [DW-1:0] data; int cyc; } strb_t;
  typedef struct { logic [DW-1:0] rdata; logic last; int first; int hs; } rsp_t;

  strb_t strb_q[$];
  rsp_t  rsp_q[$];
  int    hs_q[$];
  int    cyc = 0;
  logic  pend = 1'b0;
  rsp_t  cur;
  strb_t mon_s;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      pend = 1'b0;
    end else begin
      chk("strobe_excl", 64'(gb_we & gb_re), 64'd0);
      chk("bus_quiet_in_resp", 64'(rsp_valid & (gb_we | gb_re)), 64'd0);
      chk("ready_vs_busy", 64'(req_ready), 64'(!busy));
      if (req_valid && req_ready) hs_q.push_back(cyc);
      if (gb_we || gb_re) begin
        mon_s.we = gb_we; mon_s.addr = gb_addr; mon_s.data = gb_dout; mon_s.cyc = cyc;
        strb_q.push_back(mon_s);
      end
      if (rsp_valid) begin
        if (!pend) begin
          pend = 1'b1;
          cur.rdata = rsp_rdata; cur.last = rsp_last; cur.first = cyc;
        end else begin
          chk("rsp_stable", {31'b0, rsp_last, rsp_rdata}, {31'b0, cur.last, cur.rdata});
        end
        if (rsp_ready) begin
          cur.hs = cyc;
          rsp_q.push_back(cur);
          pend = 1'b0;
        end
      end
    end
  end

  // rsp_ready driver: 0 = always ready, 1 = random, 2 = stall 10 valid cycles.
  int rdy_mode = 0;
  int stall_cnt = 0;
  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0: rsp_ready = 1'b1;
      1: rsp_ready = 1'($urandom_range(0, 1));
      default: begin
        rsp_ready = (stall_cnt >= 10);
        if (rsp_valid && stall_cnt < 10) stall_cnt++;
      end
    endcase
  end

  task automatic mon_clear();
    strb_q.delete();
    rsp_q.delete();
    hs_q.delete();
  endtask

  task automatic issue(input logic we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, input logic [CW-1:0] len);
    int budget;
    @(posedge clk); #2;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_len = len;
    budget = 0;
    while (hs_q.size() == 0 && budget < 50) begin
      @(posedge clk); #2;
      budget++;
    end
    chk("req_accepted", 64'(hs_q.size()), 64'd1);
    req_valid = 1'b0;
    req_wdata = $urandom;
    req_len = CW'($urandom);
  endtask

  // One complete request, checked against the expected word sequence and timing.
  task automatic run_req(input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [CW-1:0] len,
                         input int mode, output int nrsp);
    int n, budget;
    logic [AW-1:0] ea;
    n = words_of(we, len);
    mon_clear();
    rdy_mode = mode;
    issue(we, addr, wdata, len);
    budget = 0;
    while (!(rsp_q.size() >= n && !busy) && budget < 400) begin
      @(posedge clk); #2;
      budget++;
    end
    chk("n_strobes", 64'(strb_q.size()), 64'(n));
    chk("n_rsp", 64'(rsp_q.size()), 64'(n));
    chk("busy_after", 64'(busy), 64'd0);
    for (int i = 0; i < n && i < strb_q.size() && i < rsp_q.size() && hs_q.size() > 0; i++) begin
      ea = addr + AW'(i);
      chk("strobe_we", 64'(strb_q[i].we), 64'(we));
      chk("strobe_addr", 64'(strb_q[i].addr), 64'(ea));
      if (we) chk("strobe_data", 64'(strb_q[i].data), 64'(wdata));
      chk("rsp_rdata", 64'(rsp_q[i].rdata), we ? 64'd0 : 64'(rdata_of(ea)));
      chk("rsp_last", 64'(rsp_q[i].last), 64'(i == n - 1));
      if (i == 0) chk("strobe_after_req", 64'(strb_q[0].cyc - hs_q[0]), 64'd1);
      else        chk("strobe_after_rsp", 64'(strb_q[i].cyc - rsp_q[i-1].hs), 64'd1);
      chk("rsp_latency", 64'(rsp_q[i].first - strb_q[i].cyc), we ? 64'd1 : 64'(RD_DELAY + 1));
    end
    nrsp = rsp_q.size();
    rdy_mode = 0;
  endtask

  typedef struct {
    logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; logic [CW-1:0] len;
    logic [DW-1:0] exp_rdata; int exp_lat;
  } vec_t;

  vec_t vecs[5];
  int   nr, tot_rsp, exp_tot, budget;
  logic rw;
  logic [CW-1:0] rl;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_len = '0; rsp_ready = 1'b1;

    vecs[0] = '{1'b1, 24'h000010, 32'hDEADBEEF, 8'd0, 32'h00000000, 2};
    vecs[1] = '{1'b0, 24'h000020, 32'h00000000, 8'd0, 32'h12345678, 4};
    vecs[2] = '{1'b1, 24'hFFFFFF, 32'h0BADF00D, 8'd5, 32'h00000000, 2};
    vecs[3] = '{1'b0, 24'h000001, 32'h00000000, 8'd0, 32'h9E3779B2, 4};
    vecs[4] = '{1'b0, 24'h000020, 32'hFFFFFFFF, 8'd0, 32'h12345678, 4};

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_outputs", {50'b0, rsp_valid, rsp_last, busy, gb_we, gb_re, 9'b0},
        64'd0);
    chk("rst_data", {rsp_rdata, gb_dout}, 64'd0);
    chk("rst_addr", 64'(gb_addr), 64'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk); #1;
    chk("ready_after_rst", 64'(req_ready), 64'd1);

    // Table-driven single accesses.
    for (int v = 0; v < 5; v++) begin
      run_req(vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].len, 0, nr);
      if (rsp_q.size() > 0 && hs_q.size() > 0) begin
        chk("vec_rdata", 64'(rsp_q[0].rdata), 64'(vecs[v].exp_rdata));
        chk("vec_latency", 64'(rsp_q[0].first - hs_q[0]), 64'(vecs[v].exp_lat));
      end else begin
        chk("vec_has_rsp", 64'(rsp_q.size()), 64'd1);
      end
    end

    // Burst across the address wrap.
    run_req(1'b0, 24'hFFFFFE, 32'h0, 8'd3, 0, nr);
`ifdef GHOSTBUS_HOST_AUTOINC_EN
    chk("burst_words", 64'(nr), 64'd4);
    if (strb_q.size() == 4) begin
      chk("burst_a2", 64'(strb_q[2].addr), 64'h000000);
      chk("burst_a3", 64'(strb_q[3].addr), 64'h000001);
      chk("burst_spacing", 64'(strb_q[1].cyc - strb_q[0].cyc), 64'(RD_DELAY + 2));
    end
`else
    chk("single_words", 64'(nr), 64'd1);
`endif

    // Backpressure: 10 stalled valid cycles on a read.
    stall_cnt = 0;
    run_req(1'b0, 24'h000040, 32'h0, 8'd0, 2, nr);
    if (rsp_q.size() > 0) chk("stall_cycles", 64'(rsp_q[0].hs - rsp_q[0].first), 64'd10);

    // Reset during WAIT of the second word (first word without auto-increment).
    mon_clear();
    rdy_mode = 0;
    issue(1'b0, 24'h000100, 32'h0, 8'd3);
    budget = 0;
`ifdef GHOSTBUS_HOST_AUTOINC_EN
    while (strb_q.size() < 2 && budget < 100) begin @(posedge clk); #2; budget++; end
    chk("mid_burst_reached", 64'(strb_q.size()), 64'd2);
`else
    while (strb_q.size() < 1 && budget < 100) begin @(posedge clk); #2; budget++; end
    chk("mid_read_reached", 64'(strb_q.size()), 64'd1);
`endif
    rst = 1'b1;
    #1;
    chk("midrst_strobes", {62'b0, gb_we, gb_re}, 64'd0);
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_req_ready", 64'(req_ready), 64'd0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    mon_clear();
    repeat (8) @(posedge clk);
    #2;
    chk("post_rst_quiet", 64'(strb_q.size() + rsp_q.size()), 64'd0);
    run_req(1'b0, 24'h000020, 32'h0, 8'd0, 0, nr);
    run_req(1'b1, 24'h000300, 32'hCAFEF00D, 8'd0, 0, nr);

    // Randomized mixed traffic with random response backpressure.
    tot_rsp = 0;
    exp_tot = 0;
    for (int t = 0; t < 200; t++) begin
      rw = 1'($urandom_range(0, 1));
      rl = CW'($urandom_range(0, 3));
      run_req(rw, AW'($urandom), $urandom, rl, int'($urandom_range(0, 1)), nr);
      tot_rsp += nr;
      exp_tot += words_of(rw, rl);
    end
    chk("rsp_total", 64'(tot_rsp), 64'(exp_tot));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
